// File: rtl/systolic_sequencer_if.sv
// Handshake and array-control signals between the tile scheduler/consumer
// (master) and the systolic tile sequencer (slave).
interface systolic_sequencer_if #(
  parameter int unsigned dim_p = 4
);
  logic             start_valid_i;
  logic             start_ready_o;
  logic             abort_i;
  logic             acc_clear_o;
  logic [dim_p-1:0] row_en_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [dim_p-1:0] out_row_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_valid_i,
    output abort_i,
    output out_ready_i,
    input  start_ready_o,
    input  acc_clear_o,
    input  row_en_o,
    input  out_valid_o,
    input  out_row_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_valid_i,
    input  abort_i,
    input  out_ready_i,
    output start_ready_o,
    output acc_clear_o,
    output row_en_o,
    output out_valid_o,
    output out_row_o,
    output busy_o,
    output done_o
  );
endinterface

// File: rtl/systolic_sequencer.sv
// Tile controller for a dim_p x dim_p output-stationary systolic array:
// clear, skewed operand feed, flush, row-by-row drain, done pulse.
module systolic_sequencer #(
  parameter int unsigned dim_p = 4,
  parameter int unsigned k_p   = 8
) (
  input logic                clk_i,
  input logic                reset_n_i,
  systolic_sequencer_if.slave bus
);

  localparam int unsigned t_w        = $clog2(k_p + dim_p);
  localparam int unsigned feed_last  = k_p + dim_p - 2;
  localparam int unsigned flush_last = dim_p - 1;

  typedef enum logic [2:0] {
    st_idle  = 3'd0,
    st_clear = 3'd1,
    st_feed  = 3'd2,
    st_flush = 3'd3,
    st_drain = 3'd4,
    st_done  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [t_w-1:0]   t_q, t_d;
  logic [dim_p-1:0] row_q, row_d;

  logic             start_ready_c;
  logic             acc_clear_c;
  logic [dim_p-1:0] row_en_c;
  logic             out_valid_c;
  logic [dim_p-1:0] out_row_c;
  logic             busy_c;
  logic             done_c;

  // State and counter registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= st_idle;
      t_q     <= '0;
      row_q   <= dim_p'(1);
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      row_q   <= row_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    row_d   = row_q;
    unique case (state_q)
      st_idle: begin
        t_d   = '0;
        row_d = dim_p'(1);
        if (!bus.abort_i && bus.start_valid_i) state_d = st_clear;
      end
      st_clear: begin
        t_d     = '0;
        state_d = st_feed;
      end
      st_feed: begin
        if (t_q == t_w'(feed_last)) begin
          t_d     = '0;
          state_d = st_flush;
        end else begin
          t_d = t_q + t_w'(1);
        end
      end
      st_flush: begin
        if (t_q == t_w'(flush_last)) begin
          t_d     = '0;
          row_d   = dim_p'(1);
          state_d = st_drain;
        end else begin
          t_d = t_q + t_w'(1);
        end
      end
      st_drain: begin
        if (bus.out_ready_i) begin
          if (row_q[dim_p-1]) begin
            row_d   = dim_p'(1);
            state_d = st_done;
          end else begin
            row_d = {row_q[dim_p-2:0], row_q[dim_p-1]};
          end
        end
      end
      st_done: begin
        state_d = st_idle;
      end
      default: begin
        t_d     = '0;
        row_d   = dim_p'(1);
        state_d = st_idle;
      end
    endcase

    // Abort cancels the tile from any active state without a done pulse
    if (state_q != st_idle && bus.abort_i) begin
      state_d = st_idle;
      t_d     = '0;
      row_d   = dim_p'(1);
    end
  end

  // Moore output decode from state and counters only
  always_comb begin
    start_ready_c = 1'b0;
    acc_clear_c   = 1'b0;
    row_en_c      = '0;
    out_valid_c   = 1'b0;
    out_row_c     = '0;
    done_c        = 1'b0;
    busy_c        = (state_q != st_idle);
    unique case (state_q)
      st_idle:  start_ready_c = 1'b1;
      st_clear: acc_clear_c   = 1'b1;
      st_feed: begin
        // Row i is enabled for k_p steps, skewed by i cycles behind row 0
        for (int unsigned i = 0; i < dim_p; i++) begin
          row_en_c[i] = (t_q >= t_w'(i)) && (t_q < t_w'(i + k_p));
        end
      end
      st_drain: begin
        out_valid_c = 1'b1;
        out_row_c   = row_q;
      end
      st_done:  done_c = 1'b1;
      default:  ;
    endcase
  end

  assign bus.start_ready_o = start_ready_c;
  assign bus.acc_clear_o   = acc_clear_c;
  assign bus.row_en_o      = row_en_c;
  assign bus.out_valid_o   = out_valid_c;
  assign bus.out_row_o     = out_row_c;
  assign bus.busy_o        = busy_c;
  assign bus.done_o        = done_c;

endmodule

// File: tb/tb_systolic_sequencer.sv
// Scoreboard bench for systolic_sequencer: per-cycle expected output vectors are
// queued as stimulus is driven and compared at the following falling edge.
module tb_systolic_sequencer;

  logic clk_i = 1'b0;
  logic reset_n_i;
  always #5 clk_i = ~clk_i;

  systolic_sequencer_if #(.dim_p(4)) ifa();
  systolic_sequencer_if #(.dim_p(2)) ifb();

  systolic_sequencer #(.dim_p(4), .k_p(8)) dut_a (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (ifa.slave)
  );

  systolic_sequencer #(.dim_p(2), .k_p(1)) dut_b (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .bus       (ifb.slave)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [12:0] exp_q[$];
  string       tag_q[$];
  bit          use_b = 1'b0;

  // Row-enable patterns taken directly from the expected feed sequences
  logic [3:0] feed_a [0:10] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                4'hE, 4'hC, 4'h8};
  logic [3:0] feed_b [0:1]  = '{4'h1, 4'h2};

  // flags = {start_ready, busy, acc_clear, done, out_valid}
  localparam logic [4:0] f_idle  = 5'b10000;
  localparam logic [4:0] f_clear = 5'b01100;
  localparam logic [4:0] f_run   = 5'b01000;
  localparam logic [4:0] f_drain = 5'b01001;
  localparam logic [4:0] f_done  = 5'b01010;

  function automatic logic [12:0] mk(input logic [4:0] flags, input logic [3:0] re,
                                     input logic [3:0] orow);
    return {flags, re, orow};
  endfunction

  function automatic logic [12:0] obs_vec();
    if (use_b)
      return {ifb.start_ready_o, ifb.busy_o, ifb.acc_clear_o, ifb.done_o, ifb.out_valid_o,
              2'b00, ifb.row_en_o, 2'b00, ifb.out_row_o};
    else
      return {ifa.start_ready_o, ifa.busy_o, ifa.acc_clear_o, ifa.done_o, ifa.out_valid_o,
              ifa.row_en_o, ifa.out_row_o};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard pop: one expected vector per cycle, sampled mid-cycle
  always @(negedge clk_i) begin
    logic [12:0] e;
    string       t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_eq(t, 32'(obs_vec()), 32'(e));
    end
  end

  // Drive one cycle of inputs and queue the outputs expected during that cycle
  task automatic step(input bit sv, input bit ab, input bit rdy, input logic [12:0] e,
                      input string tag);
    #2;
    if (use_b) begin
      ifb.start_valid_i = sv;
      ifb.abort_i       = ab;
      ifb.out_ready_i   = rdy;
    end else begin
      ifa.start_valid_i = sv;
      ifa.abort_i       = ab;
      ifa.out_ready_i   = rdy;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk_i);
  endtask

  // One tile from the IDLE start cycle through DONE; rdy_pat gives drain-cycle
  // ready values LSB first (1 once exhausted)
  task automatic run_tile(input bit hold_start, input logic [15:0] rdy_pat,
                          input int abort_at, input bit stop_in_drain);
    int         dim;
    int         nfeed;
    int         r;
    int         bi;
    bit         rdy;
    bit         ab;
    logic [3:0] re;
    dim   = use_b ? 2 : 4;
    nfeed = use_b ? 2 : 11;
    step(1'b1, 1'b0, 1'b1, mk(f_idle, 4'h0, 4'h0), "idle_start");
    step(hold_start, 1'b0, 1'b1, mk(f_clear, 4'h0, 4'h0), "clear");
    for (int i = 0; i < nfeed; i++) begin
      re = use_b ? feed_b[i] : feed_a[i];
      ab = (i == abort_at);
      step(hold_start, ab, 1'b1, mk(f_run, re, 4'h0), "feed");
      if (ab) begin
        step(1'b0, 1'b0, 1'b1, mk(f_idle, 4'h0, 4'h0), "post_abort");
        return;
      end
    end
    for (int i = 0; i < dim; i++)
      step(hold_start, 1'b0, 1'b1, mk(f_run, 4'h0, 4'h0), "flush");
    r  = 0;
    bi = 0;
    while (r < dim) begin
      rdy = (bi < 16) ? rdy_pat[bi] : 1'b1;
      bi++;
      if (stop_in_drain) begin
        step(hold_start, 1'b0, 1'b0, mk(f_drain, 4'h0, 4'(1 << r)), "drain_pre_reset");
        return;
      end
      step(hold_start, 1'b0, rdy, mk(f_drain, 4'h0, 4'(1 << r)), "drain");
      if (rdy) r++;
    end
    step(hold_start, 1'b0, 1'b1, mk(f_done, 4'h0, 4'h0), "done");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n_i         = 1'b0;
    ifa.start_valid_i = 1'b0;
    ifa.abort_i       = 1'b0;
    ifa.out_ready_i   = 1'b0;
    ifb.start_valid_i = 1'b0;
    ifb.abort_i       = 1'b0;
    ifb.out_ready_i   = 1'b0;
    #12;
    check_eq("reset_a", 32'(obs_vec()), 32'(mk(f_idle, 4'h0, 4'h0)));
    #1 reset_n_i = 1'b1;
    @(posedge clk_i);

    // Idle after reset
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "idle");
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "idle");

    // Normal tile, ready held high
    run_tile(1'b0, 16'hFFFF, -1, 1'b0);
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "after_tile");

    // Drain backpressure 1,0,0,1,1,0,1
    run_tile(1'b0, 16'h0059, -1, 1'b0);
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "after_stall_tile");

    // Abort beats start in IDLE
    step(1'b1, 1'b1, 1'b1, mk(f_idle, 4'h0, 4'h0), "abort_vs_start");
    step(1'b0, 1'b0, 1'b1, mk(f_idle, 4'h0, 4'h0), "abort_idle_hold");

    // Abort at FEED t=5 then full restart
    run_tile(1'b0, 16'hFFFF, 5, 1'b0);
    run_tile(1'b0, 16'hFFFF, -1, 1'b0);
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "after_restart");

    // Asynchronous reset mid-DRAIN
    run_tile(1'b0, 16'hFFFF, -1, 1'b1);
    #3 reset_n_i = 1'b0;
    #1 check_eq("reset_mid_drain", 32'(obs_vec()), 32'(mk(f_idle, 4'h0, 4'h0)));
    @(negedge clk_i);
    check_eq("reset_held", 32'(obs_vec()), 32'(mk(f_idle, 4'h0, 4'h0)));
    reset_n_i = 1'b1;
    @(posedge clk_i);
    step(1'b0, 1'b0, 1'b1, mk(f_idle, 4'h0, 4'h0), "after_reset");

    // Start held high: back-to-back tiles, one IDLE cycle between
    run_tile(1'b1, 16'hFFFF, -1, 1'b0);
    run_tile(1'b1, 16'hFFFF, -1, 1'b0);
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "after_b2b");

    // Small configuration dim_p=2, k_p=1
    ifa.out_ready_i = 1'b0;
    use_b = 1'b1;
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "idle_b");
    run_tile(1'b0, 16'hFFFF, -1, 1'b0);
    step(1'b0, 1'b0, 1'b0, mk(f_idle, 4'h0, 4'h0), "after_tile_b");

    @(negedge clk_i);
    if (exp_q.size() != 0)
      check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
